// File: rtl/fifo_packer.sv
// fifo_packer: drains a first-word-fall-through FiFo and packs PACK
// consecutive DATA_WIDTH entries into one wide word on a valid/ready stream.
// A flush pulse emits a partially filled word; unfilled slots read zero.
module fifo_packer #(
  parameter int DATA_WIDTH = 2,
  parameter int PACK       = 4,
  parameter int CW         = $clog2(PACK + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      io_fifo_dout,
  input  logic                       io_fifo_empty,
  output logic                       io_fifo_pop,
  input  logic                       io_flush,
  output logic [DATA_WIDTH*PACK-1:0] io_out_data,
  output logic [CW-1:0]              io_out_count,
  output logic                       io_out_valid,
  input  logic                       io_out_ready
);

  localparam int                    OW     = DATA_WIDTH * PACK;
  localparam logic [CW-1:0]         PACK_C = CW'(PACK);
  localparam logic [CW-1:0]         ONE_C  = CW'(1);

  // FILL collects entries; HOLD presents a finished word until accepted
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [OW-1:0]   data_reg,  data_next;
  logic            pop;

  // Next-state, next word contents and the FiFo pop strobe
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    data_next  = data_reg;
    // Pop whenever there is room: always in FILL, in HOLD only when the held
    // word leaves this cycle. Held low during reset so the FiFo is untouched.
    pop = reset & ~io_fifo_empty &
          ((state_reg == FILL) | ((state_reg == HOLD) & io_out_ready));
    case (state_reg)
      FILL: begin
        if (pop) begin
          for (int k = 0; k < PACK; k++) begin
            if (count_reg == CW'(k)) begin
              data_next[k*DATA_WIDTH +: DATA_WIDTH] = io_fifo_dout;
            end
          end
          count_next = count_reg + ONE_C;
          if (count_next == PACK_C) begin
            state_next = HOLD;
          end
        end
        // A flush closes the word, including an entry popped this same cycle;
        // with nothing collected there is nothing to emit.
        if (io_flush && ((count_reg != '0) || pop)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Flush is ignored here; only acceptance moves the word on.
        if (io_out_ready) begin
          data_next  = '0;
          state_next = FILL;
          if (pop) begin
            // Start the next word immediately so a steady stream has no bubble
            data_next[DATA_WIDTH-1:0] = io_fifo_dout;
            count_next = ONE_C;
          end else begin
            count_next = '0;
          end
        end
      end
      default: begin
        state_next = FILL;
        count_next = '0;
        data_next  = '0;
      end
    endcase
  end

  // State, entry count and packed word registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FILL;
      count_reg <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      data_reg  <= data_next;
    end
  end

  assign io_fifo_pop  = pop;
  assign io_out_data  = data_reg;
  assign io_out_count = count_reg;
  assign io_out_valid = (state_reg == HOLD);

endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: randomized and directed stimulus for fifo_packer with a
// queue-based FiFo model, a word-level reference model and a scoreboard
// monitor that checks every accepted output word.
module tb_fifo_packer;

  localparam int DW   = 2;
  localparam int PACK = 4;
  localparam int CW   = $clog2(PACK + 1);
  localparam int OW   = DW * PACK;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] io_fifo_dout = '0;
  logic          io_fifo_empty = 1'b1;
  logic          io_fifo_pop;
  logic          io_flush = 1'b0;
  logic [OW-1:0] io_out_data;
  logic [CW-1:0] io_out_count;
  logic          io_out_valid;
  logic          io_out_ready = 1'b0;

  fifo_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_fifo_dout (io_fifo_dout),
    .io_fifo_empty(io_fifo_empty),
    .io_fifo_pop  (io_fifo_pop),
    .io_flush     (io_flush),
    .io_out_data  (io_out_data),
    .io_out_count (io_out_count),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FiFo contents, entries collected for the current word, finished words
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] cur_q[$];
  logic [OW-1:0] exp_data_q[$];
  int            exp_cnt_q[$];
  bit            held = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word value from a list of entries: entry k occupies bits k*DW upward
  function automatic logic [OW-1:0] pack_word(input logic [DW-1:0] e[$]);
    logic [OW-1:0] w = '0;
    for (int k = 0; k < e.size(); k++) begin
      w = w | (OW'(e[k]) << (k * DW));
    end
    return w;
  endfunction

  // One clock cycle: drive inputs at negedge, check and advance the model
  // just before the next posedge.
  task automatic step(input bit ready, input bit flush);
    bit was_held, exp_pop;
    @(negedge clk);
    io_out_ready  = ready;
    io_flush      = flush;
    io_fifo_empty = (fifo_q.size() == 0);
    io_fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    #4;
    was_held = held;
    exp_pop  = !io_fifo_empty && (!was_held || ready);
    chk("pop", 32'(io_fifo_pop), 32'(exp_pop));
    chk("valid", 32'(io_out_valid), 32'(was_held));
    if (was_held && ready) held = 1'b0;
    if (exp_pop) cur_q.push_back(fifo_q.pop_front());
    if (!was_held && ((cur_q.size() == PACK) || (flush && cur_q.size() > 0))) begin
      exp_data_q.push_back(pack_word(cur_q));
      exp_cnt_q.push_back(cur_q.size());
      cur_q.delete();
      held = 1'b1;
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic mid_reset();
    @(negedge clk);
    io_flush      = 1'b0;
    io_fifo_empty = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(io_out_valid), 32'd0);
    chk("rst_data", 32'(io_out_data), 32'd0);
    chk("rst_count", 32'(io_out_count), 32'd0);
    io_fifo_empty = 1'b0;
    #1;
    chk("rst_pop", 32'(io_fifo_pop), 32'd0);
    io_fifo_empty = 1'b1;
    cur_q.delete();
    exp_data_q.delete();
    exp_cnt_q.delete();
    held = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // Monitor: compare every accepted word against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset && io_out_valid && io_out_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: got unexpected data %0h count %0d expected no word", io_out_data, io_out_count);
        end else begin
          logic [OW-1:0] ed;
          int            ec;
          ed = exp_data_q.pop_front();
          ec = exp_cnt_q.pop_front();
          $display("word data=%b count=%0d (expected %b/%0d) t=%0t", io_out_data, io_out_count, ed, ec, $time);
          chk("word_data", 32'(io_out_data), 32'(ed));
          chk("word_count", 32'(io_out_count), 32'(ec));
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("init_valid", 32'(io_out_valid), 32'd0);
    chk("init_count", 32'(io_out_count), 32'd0);
    chk("init_data", 32'(io_out_data), 32'd0);
    chk("init_pop", 32'(io_fifo_pop), 32'd0);
    #20 reset = 1'b1;

    // Single full word, downstream always ready
    push(1); push(2); push(3); push(0);
    repeat (6) step(1, 0);

    // Backpressure: word held while more entries wait
    for (int i = 0; i < 8; i++) push(DW'(i));
    repeat (4) step(0, 0);
    repeat (5) step(0, 0);
    repeat (8) step(1, 0);

    // Flush a two-entry partial word
    push(2); push(3);
    repeat (3) step(1, 0);
    step(1, 1);
    repeat (3) step(1, 0);

    // Flush together with the popping of the entry that completes nothing
    push(1);
    step(1, 1);
    repeat (3) step(1, 0);

    // Sustained stream of 12 entries
    for (int i = 0; i < 12; i++) push(DW'(3 - (i % 4)));
    repeat (16) step(1, 0);

    // Reset in the middle of a word, then a clean word
    push(1); push(2);
    repeat (2) step(1, 0);
    mid_reset();
    push(3); push(1); push(2); push(0);
    repeat (7) step(1, 0);

    // Flush with nothing collected, then flush while a word is held
    step(1, 1);
    step(1, 0);
    push(1); push(1); push(2); push(2); push(3);
    repeat (5) step(0, 0);
    step(0, 1);
    step(0, 0);
    repeat (5) step(1, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) push(DW'($urandom));
      step(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 9) == 0));
    end

    // Drain with a bounded number of cycles
    for (int c = 0; c < 40 && (fifo_q.size() > 0 || held); c++) step(1, 0);
    step(1, 1);
    for (int c = 0; c < 5; c++) step(1, 0);
    chk("drain_words_left", 32'(exp_data_q.size()), 32'd0);
    chk("drain_fifo_left", 32'(fifo_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
